// File: rtl/mux_select_bank.sv
// -----------------------------------------------------------------------------
// mux_select_bank
//
// Selector bank over a shared pool of 32 data words. Three independent
// binary-select paths are provided:
//   - a 2-to-1 path over words 0..1
//   - a 16-to-1 path over words 0..15
//   - a 32-to-1 path over words 0..31
// Each path has a zero-latency combinational output and a registered copy.
// The registered copies are captured together under a shared enable. This is a
// pure datapath block with no handshake and no FSM. The only state is the
// three output registers.
//
// Parameters:
//   N       width of each data word and of every output
//   NUM_IN  number of words in the input pool (only 32 is supported)
//
// Ports:
//   clk    in   1         rising-edge clock for the registered outputs
//   rst_n  in   1         asynchronous active-low reset, clears the _q outputs
//   d_in   in   NUM_IN*N  flattened pool, word k = d_in[k*N +: N]
//   sel2   in   1         select for the 2-to-1 path
//   sel16  in   4         select for the 16-to-1 path
//   sel32  in   5         select for the 32-to-1 path
//   en     in   1         capture enable for all three output registers
//   y2     out  N         word[sel2], combinational
//   y16    out  N         word[sel16], combinational
//   y32    out  N         word[sel32], combinational
//   y2_q   out  N         registered y2
//   y16_q  out  N         registered y16
//   y32_q  out  N         registered y32
// -----------------------------------------------------------------------------
module mux_select_bank #(
    parameter int N      = 32,
    parameter int NUM_IN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_IN*N-1:0] d_in,
    input  logic                sel2,
    input  logic [3:0]          sel16,
    input  logic [4:0]          sel32,
    input  logic                en,
    output logic [N-1:0]        y2,
    output logic [N-1:0]        y16,
    output logic [N-1:0]        y32,
    output logic [N-1:0]        y2_q,
    output logic [N-1:0]        y16_q,
    output logic [N-1:0]        y32_q
);

    // Unpack the flat pool into an indexable word array.
    logic [N-1:0] words [NUM_IN];

    always_comb begin
        for (int k = 0; k < NUM_IN; k++) begin
            words[k] = d_in[k*N +: N];
        end
    end

    // Combinational paths. Every select code is a legal index. The 16-to-1 path
    // zero-extends its select so it can only reach the lower half of the pool.
    always_comb begin
        y2  = sel2 ? words[1] : words[0];
        y16 = words[{1'b0, sel16}];
        y32 = words[sel32];
    end

    // Registered copies. Reset is asynchronous and overrides any capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y2_q  <= '0;
            y16_q <= '0;
            y32_q <= '0;
        end else if (en) begin
            y2_q  <= y2;
            y16_q <= y16;
            y32_q <= y32;
        end
    end

endmodule

// File: tb/tb_mux_select_bank.sv
// -----------------------------------------------------------------------------
// tb_mux_select_bank
//
// Directed bench for mux_select_bank. It covers the following areas:
//   - reset values
//   - select sweeps over a known pattern
//   - a seeded random pool
//   - isolation between the paths
//   - boundary selects
//   - enable hold
//   - asynchronous reset in the middle of operation
//   - zero-clock response of the combinational path
// Registered expectations go through an expected queue.
// -----------------------------------------------------------------------------
module tb_mux_select_bank;

  localparam int N      = 32;
  localparam int NUM_IN = 32;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [NUM_IN*N-1:0] d_in;
  logic                sel2;
  logic [3:0]          sel16;
  logic [4:0]          sel32;
  logic                en;
  logic [N-1:0]        y2, y16, y32, y2_q, y16_q, y32_q;

  mux_select_bank #(.N(N), .NUM_IN(NUM_IN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (d_in),
    .sel2  (sel2),
    .sel16 (sel16),
    .sel32 (sel32),
    .en    (en),
    .y2    (y2),
    .y16   (y16),
    .y32   (y32),
    .y2_q  (y2_q),
    .y16_q (y16_q),
    .y32_q (y32_q)
  );

  // ---------------- scoreboard ----------------
  logic [N-1:0] pool [NUM_IN];
  logic [N-1:0] exp_q [$];
  int n_cmp;
  int n_err;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_pool();
    for (int k = 0; k < NUM_IN; k++) d_in[k*N +: N] = pool[k];
    #1;
  endtask

  task automatic drive_sel(input logic s2, input logic [3:0] s16, input logic [4:0] s32);
    sel2  = s2;
    sel16 = s16;
    sel32 = s32;
    #1;
  endtask

  // Push the expected register contents, clock once, then compare against the queue.
  task automatic clock_and_check(input string tag,
                                 input logic [N-1:0] e2,
                                 input logic [N-1:0] e16,
                                 input logic [N-1:0] e32);
    exp_q.push_back(e2);
    exp_q.push_back(e16);
    exp_q.push_back(e32);
    @(posedge clk);
    #1;
    check({tag, "_y2_q"},  y2_q,  exp_q.pop_front());
    check({tag, "_y16_q"}, y16_q, exp_q.pop_front());
    check({tag, "_y32_q"}, y32_q, exp_q.pop_front());
  endtask

  // Watchdog: the bench must never hang.
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] save2, save16;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    sel2  = 1'b0;
    sel16 = 4'h0;
    sel32 = 5'h00;
    for (int k = 0; k < NUM_IN; k++) pool[k] = 32'hA500_0000 + 32'(k);
    drive_pool();

    // Reset state: the registers are cleared, and the combinational paths track
    // their inputs even while in reset.
    repeat (2) @(posedge clk);
    #1;
    check("rst_y2_q",  y2_q,  32'h0);
    check("rst_y16_q", y16_q, 32'h0);
    check("rst_y32_q", y32_q, 32'h0);
    check("rst_y32_comb", y32, 32'hA500_0000);
    rst_n = 1'b1;
    #1;

    // Known-pattern sweeps.
    for (int s = 0; s < 2; s++) begin
      drive_sel(s[0], 4'h0, 5'h00);
      check("sweep_y2", y2, 32'hA500_0000 + 32'(s));
    end
    for (int s = 0; s < 16; s++) begin
      drive_sel(1'b0, s[3:0], 5'h00);
      check("sweep_y16", y16, 32'hA500_0000 + 32'(s));
    end
    for (int s = 0; s < 32; s++) begin
      drive_sel(1'b0, 4'h0, s[4:0]);
      check("sweep_y32", y32, 32'hA500_0000 + 32'(s));
    end

    // Path independence: moving sel32 alone leaves y2 and y16 alone.
    drive_sel(1'b1, 4'h9, 5'h03);
    drive_sel(1'b1, 4'h9, 5'h1C);
    check("indep_y2",  y2,  32'hA500_0001);
    check("indep_y16", y16, 32'hA500_0009);
    check("indep_y32", y32, 32'hA500_001C);

    // Random pool with random selects. The expected values come from the bench's pool copy.
    for (int it = 0; it < 200; it++) begin
      logic [4:0] r32;
      logic [3:0] r16;
      logic       r2;
      if (it % 20 == 0) begin
        for (int k = 0; k < NUM_IN; k++) pool[k] = $urandom;
        drive_pool();
      end
      r2  = 1'($urandom_range(0, 1));
      r16 = 4'($urandom_range(0, 15));
      r32 = 5'($urandom_range(0, 31));
      drive_sel(r2, r16, r32);
      check("rnd_y2",  y2,  pool[{4'b0, r2}]);
      check("rnd_y16", y16, pool[{1'b0, r16}]);
      check("rnd_y32", y32, pool[r32]);
    end

    // Changing the upper words must not reach y2 or y16.
    save2  = y2;
    save16 = y16;
    for (int k = 16; k < NUM_IN; k++) pool[k] = ~pool[k];
    drive_pool();
    check("upper_y2",  y2,  save2);
    check("upper_y16", y16, save16);

    // Boundary selects.
    pool[31] = 32'hFFFF_FFFF;
    pool[15] = 32'h0000_0001;
    drive_pool();
    drive_sel(1'b0, 4'hF, 5'h1F);
    check("bound_y32", y32, 32'hFFFF_FFFF);
    check("bound_y16", y16, 32'h0000_0001);

    // Enabled capture, followed by a hold.
    pool[0] = 32'h0000_0000;
    pool[1] = 32'h1111_2222;
    pool[9] = 32'h3333_4444;
    pool[7] = 32'hDEAD_BEEF;
    drive_pool();
    drive_sel(1'b1, 4'h9, 5'h07);
    en = 1'b1;
    clock_and_check("cap", 32'h1111_2222, 32'h3333_4444, 32'hDEAD_BEEF);
    en = 1'b0;
    pool[7] = 32'h1234_5678;
    drive_pool();
    clock_and_check("hold", 32'h1111_2222, 32'h3333_4444, 32'hDEAD_BEEF);
    check("hold_y32_comb", y32, 32'h1234_5678);

    // Asynchronous reset between clock edges.
    en = 1'b1;
    clock_and_check("pre_rst", 32'h1111_2222, 32'h3333_4444, 32'h1234_5678);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_y2_q",  y2_q,  32'h0);
    check("arst_y16_q", y16_q, 32'h0);
    check("arst_y32_q", y32_q, 32'h0);
    pool[7] = 32'h5555_AAAA;
    drive_pool();
    check("arst_y32_comb", y32, 32'h5555_AAAA);
    clock_and_check("in_rst", 32'h0, 32'h0, 32'h0);
    rst_n = 1'b1;
    #1;
    clock_and_check("reload", 32'h1111_2222, 32'h3333_4444, 32'h5555_AAAA);

    // A sel2 toggle with no clock: y2 follows immediately and y2_q holds.
    en = 1'b0;
    pool[0] = 32'h0000_0000;
    pool[1] = 32'hCAFE_F00D;
    drive_pool();
    drive_sel(1'b0, 4'h9, 5'h07);
    check("tog0_y2", y2, 32'h0000_0000);
    drive_sel(1'b1, 4'h9, 5'h07);
    check("tog1_y2", y2, 32'hCAFE_F00D);
    check("tog1_y2_q", y2_q, 32'h1111_2222);
    en = 1'b1;
    clock_and_check("tog_cap", 32'hCAFE_F00D, 32'h3333_4444, 32'h5555_AAAA);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
